instr_fetch_unit: RTL and testbench

- Program-counter and fetch sequencer sitting directly upstream of the 8-bit instruction memory.
- Drives the memory read address and read strobe, and assembles 1- or 2-byte instructions (opcode + optional operand).
- Presents each complete instruction to the decoder over a valid/ready handshake.
- Handles branch redirects and the HALT opcode.

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Program counter and fetch sequencer for the 8-bit instruction memory.
// Optional accepted-instruction counter (fetch_count) enabled by FETCH_PERF_EN.
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF,
    parameter int         OPERAND_BIT = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_read,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_operand,
    output logic [7:0] instr_pc,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic       halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    // state     | meaning
    // FETCH_OP  | read opcode byte at pc
    // FETCH_ARG | read operand byte at pc
    // HOLD      | instruction presented, waiting for decoder accept
    // HALTED    | HALT delivered, fetch stopped until a branch
    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        HOLD      = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] operand_q, operand_d;
    logic [7:0] ipc_q, ipc_d;
    logic       accept;

    assign accept = (state_q == HOLD) && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
            ipc_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            ipc_q     <= ipc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        ipc_d     = ipc_q;
        case (state_q)
            FETCH_OP: begin
                opcode_d = imem_data;
                ipc_d    = pc_q;
                pc_d     = pc_q + 8'd1;
                if (imem_data[OPERAND_BIT]) begin
                    state_d = FETCH_ARG;
                end else begin
                    operand_d = 8'h00;
                    state_d   = HOLD;
                end
            end
            FETCH_ARG: begin
                operand_d = imem_data;
                pc_d      = pc_q + 8'd1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (accept) begin
                    state_d = (opcode_q == HALT_OPCODE) ? HALTED : FETCH_OP;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: state_d = FETCH_OP;
        endcase
        // Redirect wins over everything; an accept in the same cycle still completes.
        if (branch_taken) begin
            pc_d    = branch_target;
            state_d = FETCH_OP;
        end
    end

    assign imem_addr     = pc_q;
    assign imem_read     = (state_q == FETCH_OP) || (state_q == FETCH_ARG);
    assign instr_valid   = (state_q == HOLD);
    assign halted        = (state_q == HALTED);
    assign instr_opcode  = opcode_q;
    assign instr_operand = operand_q;
    assign instr_pc      = ipc_q;

`ifdef FETCH_PERF_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (accept && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Build with FETCH_PERF_EN defined to also check fetch_count.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_read;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] instr_pc;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       halted;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif

    logic [7:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instr_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_read     (imem_read),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_pc      (instr_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        branch_target = 8'h00;
        #12;
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_operand, instr_pc, halted, imem_addr, imem_read}
            !== {1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b op=%h arg=%h pc=%h h=%b addr=%h rd=%b",
                     instr_valid, instr_opcode, instr_operand, instr_pc, halted, imem_addr, imem_read);
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if (fetch_count !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_count: got %h want 0000", fetch_count);
        end
`endif
    endtask

    task automatic test_one_byte();
        instr_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_operand, instr_pc} !== {1'b1, 8'h12, 8'h00, 8'h00}) begin
            n_err++;
            $display("FAIL one_byte_first: got v=%b op=%h arg=%h pc=%h want 1 12 00 00",
                     instr_valid, instr_opcode, instr_operand, instr_pc);
        end
        tick();
        n_cmp++;
        if ({instr_valid, imem_addr, imem_read} !== {1'b0, 8'h01, 1'b1}) begin
            n_err++;
            $display("FAIL one_byte_accept: got v=%b addr=%h rd=%b want 0 01 1",
                     instr_valid, imem_addr, imem_read);
        end
        tick();
        instr_ready = 1'b0;
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_operand, instr_pc} !== {1'b1, 8'h34, 8'h00, 8'h01}) begin
            n_err++;
            $display("FAIL one_byte_second: got v=%b op=%h arg=%h pc=%h want 1 34 00 01",
                     instr_valid, instr_opcode, instr_operand, instr_pc);
        end
    endtask

    task automatic test_two_byte();
        branch_taken = 1'b1;
        branch_target = 8'h10;
        tick();
        branch_taken = 1'b0;
        n_cmp++;
        if ({instr_valid, imem_addr} !== {1'b0, 8'h10}) begin
            n_err++;
            $display("FAIL two_byte_redirect: got v=%b addr=%h want 0 10", instr_valid, imem_addr);
        end
        tick();
        n_cmp++;
        if ({instr_valid, imem_addr, imem_read} !== {1'b0, 8'h11, 1'b1}) begin
            n_err++;
            $display("FAIL two_byte_arg: got v=%b addr=%h rd=%b want 0 11 1",
                     instr_valid, imem_addr, imem_read);
        end
        tick();
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_operand, instr_pc, imem_addr}
            !== {1'b1, 8'h85, 8'hAA, 8'h10, 8'h12}) begin
            n_err++;
            $display("FAIL two_byte_present: got v=%b op=%h arg=%h pc=%h addr=%h want 1 85 AA 10 12",
                     instr_valid, instr_opcode, instr_operand, instr_pc, imem_addr);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({instr_valid, instr_opcode, instr_operand, instr_pc, imem_read}
                !== {1'b1, 8'h85, 8'hAA, 8'h10, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b op=%h arg=%h pc=%h rd=%b want 1 85 AA 10 0",
                         i, instr_valid, instr_opcode, instr_operand, instr_pc, imem_read);
            end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++;
        if ({instr_valid, imem_addr} !== {1'b0, 8'h12}) begin
            n_err++;
            $display("FAIL stall_accept: got v=%b addr=%h want 0 12", instr_valid, imem_addr);
        end
    endtask

    task automatic test_halt();
        branch_taken = 1'b1;
        branch_target = 8'h20;
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_operand, instr_pc, halted}
            !== {1'b1, 8'hFF, 8'h00, 8'h20, 1'b0}) begin
            n_err++;
            $display("FAIL halt_present: got v=%b op=%h arg=%h pc=%h h=%b want 1 FF 00 20 0",
                     instr_valid, instr_opcode, instr_operand, instr_pc, halted);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++;
        if ({halted, imem_read, instr_valid, imem_addr} !== {1'b1, 1'b0, 1'b0, 8'h22}) begin
            n_err++;
            $display("FAIL halt_enter: got h=%b rd=%b v=%b addr=%h want 1 0 0 22",
                     halted, imem_read, instr_valid, imem_addr);
        end
        tick();
        tick();
        n_cmp++;
        if ({halted, imem_read, instr_valid, imem_addr} !== {1'b1, 1'b0, 1'b0, 8'h22}) begin
            n_err++;
            $display("FAIL halt_frozen: got h=%b rd=%b v=%b addr=%h want 1 0 0 22",
                     halted, imem_read, instr_valid, imem_addr);
        end
        branch_taken = 1'b1;
        branch_target = 8'h00;
        tick();
        branch_taken = 1'b0;
        n_cmp++;
        if ({halted, imem_read, imem_addr} !== {1'b0, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL halt_exit: got h=%b rd=%b addr=%h want 0 1 00", halted, imem_read, imem_addr);
        end
        tick();
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_pc} !== {1'b1, 8'h12, 8'h00}) begin
            n_err++;
            $display("FAIL halt_resume: got v=%b op=%h pc=%h want 1 12 00", instr_valid, instr_opcode, instr_pc);
        end
    endtask

    task automatic test_wrap();
        mem[8'h00] = 8'h55;
        branch_taken = 1'b1;
        branch_target = 8'hFF;
        tick();
        branch_taken = 1'b0;
        tick();
        n_cmp++;
        if (imem_addr !== 8'h00) begin
            n_err++;
            $display("FAIL wrap_arg_addr: got %h want 00", imem_addr);
        end
        tick();
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_operand, instr_pc} !== {1'b1, 8'h90, 8'h55, 8'hFF}) begin
            n_err++;
            $display("FAIL wrap_present: got v=%b op=%h arg=%h pc=%h want 1 90 55 FF",
                     instr_valid, instr_opcode, instr_operand, instr_pc);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++;
        if ({instr_valid, imem_addr, imem_read} !== {1'b0, 8'h01, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_next: got v=%b addr=%h rd=%b want 0 01 1", instr_valid, imem_addr, imem_read);
        end
        tick();
    endtask

    task automatic test_branch_accept();
        instr_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 8'h40;
        tick();
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        n_cmp++;
        if ({instr_valid, imem_addr, halted} !== {1'b0, 8'h40, 1'b0}) begin
            n_err++;
            $display("FAIL br_accept_redirect: got v=%b addr=%h h=%b want 0 40 0", instr_valid, imem_addr, halted);
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if (fetch_count !== 16'd5) begin
            n_err++;
            $display("FAIL br_accept_count: got %0d want 5", fetch_count);
        end
`endif
        tick();
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_pc} !== {1'b1, 8'h01, 8'h40}) begin
            n_err++;
            $display("FAIL br_accept_fetch: got v=%b op=%h pc=%h want 1 01 40", instr_valid, instr_opcode, instr_pc);
        end
        branch_taken = 1'b1;
        branch_target = 8'h10;
        tick();
        branch_taken = 1'b0;
        tick();
        branch_taken = 1'b1;
        branch_target = 8'h30;
        tick();
        branch_taken = 1'b0;
        tick();
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_operand, instr_pc} !== {1'b1, 8'h01, 8'h00, 8'h30}) begin
            n_err++;
            $display("FAIL br_discard_partial: got v=%b op=%h arg=%h pc=%h want 1 01 00 30",
                     instr_valid, instr_opcode, instr_operand, instr_pc);
        end
    endtask

    task automatic test_reset_mid();
        branch_taken = 1'b1;
        branch_target = 8'h10;
        tick();
        branch_taken = 1'b0;
        tick();
        n_cmp++;
        if ({imem_addr, instr_valid} !== {8'h11, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid_pre: got addr=%h v=%b want 11 0", imem_addr, instr_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({instr_valid, imem_addr, instr_opcode, instr_operand, instr_pc, halted, imem_read}
            !== {1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rst_mid_state: got v=%b addr=%h op=%h arg=%h pc=%h h=%b rd=%b",
                     instr_valid, imem_addr, instr_opcode, instr_operand, instr_pc, halted, imem_read);
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if (fetch_count !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_mid_count: got %h want 0000", fetch_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({instr_valid, instr_opcode, instr_pc} !== {1'b1, 8'h55, 8'h00}) begin
            n_err++;
            $display("FAIL rst_mid_restart: got v=%b op=%h pc=%h want 1 55 00", instr_valid, instr_opcode, instr_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        mem[8'h00] = 8'h12;
        mem[8'h01] = 8'h34;
        mem[8'h10] = 8'h85;
        mem[8'h11] = 8'hAA;
        mem[8'h20] = 8'hFF;
        mem[8'h21] = 8'h00;
        mem[8'hFF] = 8'h90;

        test_reset();
        test_one_byte();
        test_two_byte();
        test_stall();
        test_halt();
        test_wrap();
        test_branch_accept();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
